reg_wb_arbiter: RTL

- Writer side of the CPU register file: arbitrates three result producers onto the single register-file write port (wr_addr/wr_data/write_en).
- Producers: single-cycle ALU, load unit, multi-cycle mul/div unit.
- Registers the winning result for one cycle.
- Keeps a pending-write scoreboard so decode can stall on operands still in flight.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/reg_wb_arbiter_if.sv | 51 +++++
 rtl/reg_scoreboard.sv | 47 ++++
 rtl/reg_wb_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback grant-select encoding.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD,
    WB_MULDIV
  } wb_src_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of producer handshakes, scoreboard mark/read ports and the register-file write port.
interface reg_wb_arbiter_if #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int AW   = cpu_pkg::REG_ADDR_W
);

  // Handshake: a producer holds valid and its rd/data stable until ready; the
  // result transfers at the rising edge where valid && ready. ALU has no ready.
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            md_valid;
  logic            md_ready;
  logic [AW-1:0]   md_rd;
  logic [XLEN-1:0] md_data;
  logic            stall_req;
  logic            mark_en;
  logic [AW-1:0]   mark_rd;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            write_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  md_valid, md_rd, md_data,
    input  mark_en, mark_rd, rs1_addr, rs2_addr,
    output ld_ready, md_ready, stall_req,
    output rs1_busy, rs2_busy,
    output write_en, wr_addr, wr_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output md_valid, md_rd, md_data,
    output mark_en, mark_rd, rs1_addr, rs2_addr,
    input  ld_ready, md_ready, stall_req,
    input  rs1_busy, rs2_busy,
    input  write_en, wr_addr, wr_data
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set wins over clear, x0 never busy.
// Storage exists only when WB_SCOREBOARD_EN is defined; otherwise both busy outputs are 0.
module reg_scoreboard #(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          busy_a,
  output logic          busy_b
);

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending;

  // A same-edge set means a newer producer was issued, so it overrides the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && set_addr == AW'(i)) begin
          pending[i] <= 1'b1;
        end else if (clr_en && clr_addr == AW'(i)) begin
          pending[i] <= 1'b0;
        end
      end
      pending[0] <= 1'b0;
    end
  end

  assign busy_a = pending[rd_addr_a];
  assign busy_b = pending[rd_addr_b];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{clk, reset, set_en, set_addr, clr_en, clr_addr, rd_addr_a, rd_addr_b};
  assign busy_a = 1'b0;
  assign busy_b = 1'b0;
`endif

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: ALU > load > mul/div, with a starvation escape for mul/div.
// Optional pending-write scoreboard enabled by WB_SCOREBOARD_EN.
module reg_wb_arbiter #(
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int NUM_REGS     = cpu_pkg::NUM_REGS,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             reset,
  reg_wb_arbiter_if.slave bus
);

  import cpu_pkg::*;

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  wb_src_e         grant_src;
  logic            grant_valid;
  logic [AW-1:0]   grant_rd;
  logic [XLEN-1:0] grant_data;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_cnt_next;
  logic            stall_q;

  // In starve mode mul/div overtakes load; ALU still wins if the pipeline did not hold off.
  assign bus.ld_ready  = !bus.alu_valid && !(stall_q && bus.md_valid);
  assign bus.md_ready  = !bus.alu_valid && (!bus.ld_valid || stall_q);
  assign bus.stall_req = stall_q;
  assign grant_valid   = (grant_src != WB_NONE);

  always_comb begin
    grant_src       = WB_NONE;
    grant_rd        = '0;
    grant_data      = '0;
    starve_cnt_next = starve_cnt;
    if (bus.alu_valid) begin
      grant_src  = WB_ALU;
      grant_rd   = bus.alu_rd;
      grant_data = bus.alu_data;
    end else if (bus.ld_valid && bus.ld_ready) begin
      grant_src  = WB_LOAD;
      grant_rd   = bus.ld_rd;
      grant_data = bus.ld_data;
    end else if (bus.md_valid && bus.md_ready) begin
      grant_src  = WB_MULDIV;
      grant_rd   = bus.md_rd;
      grant_data = bus.md_data;
    end
    if (!bus.md_valid || grant_src == WB_MULDIV) begin
      starve_cnt_next = '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt_next = starve_cnt + CW'(1);
    end
  end

  // Grants to x0 complete the handshake but leave the write port idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.write_en <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      starve_cnt   <= '0;
      stall_q      <= 1'b0;
    end else begin
      bus.write_en <= grant_valid && (grant_rd != '0);
      if (grant_valid && grant_rd != '0) begin
        bus.wr_addr <= grant_rd;
        bus.wr_data <= grant_data;
      end
      starve_cnt <= starve_cnt_next;
      stall_q    <= (starve_cnt_next == CNT_MAX);
    end
  end

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en    (bus.mark_en),
    .set_addr  (bus.mark_rd),
    .clr_en    (grant_valid),
    .clr_addr  (grant_rd),
    .rd_addr_a (bus.rs1_addr),
    .rd_addr_b (bus.rs2_addr),
    .busy_a    (bus.rs1_busy),
    .busy_b    (bus.rs2_busy)
  );

endmodule
